systolic_pq_sort_3: RTL and testbench

Three-input key/value sorter used as the compare-exchange cell of the systolic priority queue. Each cycle it accepts three words, orders them by key, and presents them as minimum, median and maximum on registered outputs. Neighbouring queue stages consume it to decide which entry stays, which moves up and which moves down.

---
 rtl/systolic_pq_sort_3.sv | 81 ++++++++
 tb/tb_systolic_pq_sort_3.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/systolic_pq_sort_3.sv
// systolic_pq_sort_3: stable 3-word key sorter (min/med/max), registered outputs.
// Define SYSTOLIC_PQ_SORT3_PIPE_EN to register after the first compare-exchange (2-cycle latency).
module systolic_pq_sort_3 #(
    parameter int KW = 8,
    parameter int VW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [KW+VW-1:0] a,
    input  logic [KW+VW-1:0] b,
    input  logic [KW+VW-1:0] c,
    output logic             out_valid,
    output logic [KW+VW-1:0] minv,
    output logic [KW+VW-1:0] medv,
    output logic [KW+VW-1:0] maxv
);
    localparam int W = KW + VW;

    // Strict compare keeps equal keys in input order, which makes the network stable.
    function automatic logic gt(input logic [W-1:0] p, input logic [W-1:0] q);
        return p[W-1:VW] > q[W-1:VW];
    endfunction

    logic         s0;
    logic [W-1:0] x0, y0;
    logic         v1;
    logic [W-1:0] x1, y1, z1;
    logic         s1, s2;
    logic [W-1:0] y2, z2, x3, y3;

    assign s0 = gt(a, b);
    assign x0 = s0 ? b : a;
    assign y0 = s0 ? a : b;

`ifdef SYSTOLIC_PQ_SORT3_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            x1 <= '0;
            y1 <= '0;
            z1 <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                x1 <= x0;
                y1 <= y0;
                z1 <= c;
            end
        end
    end
`else
    assign v1 = in_valid;
    assign x1 = x0;
    assign y1 = y0;
    assign z1 = c;
`endif

    assign s1 = gt(y1, z1);
    assign y2 = s1 ? z1 : y1;
    assign z2 = s1 ? y1 : z1;
    assign s2 = gt(x1, y2);
    assign x3 = s2 ? y2 : x1;
    assign y3 = s2 ? x1 : y2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            minv      <= '0;
            medv      <= '0;
            maxv      <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                minv <= x3;
                medv <= y3;
                maxv <= z2;
            end
        end
    end
endmodule

// File: tb/tb_systolic_pq_sort_3.sv
// tb_systolic_pq_sort_3: directed self-checking bench for systolic_pq_sort_3 (KW=8, VW=4).
module tb_systolic_pq_sort_3;
`ifdef SYSTOLIC_PQ_SORT3_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] a = '0, b = '0, c = '0;
    logic        out_valid;
    logic [11:0] minv, medv, maxv;
    int          checks = 0;
    int          errors = 0;

    systolic_pq_sort_3 #(.KW(8), .VW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .c(c),
        .out_valid(out_valid), .minv(minv), .medv(medv), .maxv(maxv)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic chk_set(input string tag, input logic [11:0] emin, input logic [11:0] emed,
                           input logic [11:0] emax);
        chk({tag, ".valid"}, {11'd0, out_valid}, 12'd1);
        chk({tag, ".min"}, minv, emin);
        chk({tag, ".med"}, medv, emed);
        chk({tag, ".max"}, maxv, emax);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [11:0] ia, input logic [11:0] ib,
                           input logic [11:0] ic, input logic [11:0] emin,
                           input logic [11:0] emed, input logic [11:0] emax);
        a = ia; b = ib; c = ic; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        chk_set(tag, emin, emed, emax);
    endtask

    logic [11:0] perm [6][3];
    logic [11:0] bs [3][3];
    logic [11:0] be [3][3];

    initial begin
        perm[0] = '{12'h010, 12'h020, 12'h030};
        perm[1] = '{12'h010, 12'h030, 12'h020};
        perm[2] = '{12'h020, 12'h010, 12'h030};
        perm[3] = '{12'h020, 12'h030, 12'h010};
        perm[4] = '{12'h030, 12'h010, 12'h020};
        perm[5] = '{12'h030, 12'h020, 12'h010};
        bs[0] = '{12'h0F1, 12'h102, 12'h003}; be[0] = '{12'h003, 12'h0F1, 12'h102};
        bs[1] = '{12'h7A5, 12'h7A6, 12'h006}; be[1] = '{12'h006, 12'h7A5, 12'h7A6};
        bs[2] = '{12'hFF0, 12'h001, 12'h802}; be[2] = '{12'h001, 12'h802, 12'hFF0};

        #1;
        chk("rst0.valid", {11'd0, out_valid}, 12'd0);
        chk("rst0.min", minv, 12'h000);
        tick();
        rst_n = 1'b1;
        tick();

        run_one("mix", 12'h030, 12'h010, 12'h310, 12'h010, 12'h030, 12'h310);

        // Mid-cycle async reset clears everything without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", {11'd0, out_valid}, 12'd0);
        chk("arst.min", minv, 12'h000);
        chk("arst.med", medv, 12'h000);
        chk("arst.max", maxv, 12'h000);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle.valid", {11'd0, out_valid}, 12'd0);
        chk("idle.max", maxv, 12'h000);

        for (int i = 0; i < 6; i++)
            run_one($sformatf("perm%0d", i), perm[i][0], perm[i][1], perm[i][2],
                    12'h010, 12'h020, 12'h030);

        run_one("tie2", 12'h330, 12'h220, 12'h220, 12'h220, 12'h220, 12'h330);
        run_one("tie3", 12'h055, 12'h05A, 12'h050, 12'h055, 12'h05A, 12'h050);
        run_one("tieab", 12'h551, 12'h552, 12'h103, 12'h103, 12'h551, 12'h552);

        for (int k = 0; k < 3 + LAT; k++) begin
            int idx;
            if (k < 3) begin
                a = bs[k][0]; b = bs[k][1]; c = bs[k][2]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
                a = 12'hABC; b = 12'h123; c = 12'h456;
            end
            tick();
            idx = k - LAT + 1;
            if (idx >= 0 && idx < 3)
                chk_set($sformatf("b2b%0d", idx), be[idx][0], be[idx][1], be[idx][2]);
            else if (idx == 3) begin
                chk("b2b.drop", {11'd0, out_valid}, 12'd0);
                chk("b2b.hold.min", minv, be[2][0]);
                chk("b2b.hold.med", medv, be[2][1]);
                chk("b2b.hold.max", maxv, be[2][2]);
            end
        end

        // A set presented while reset is low must never surface as valid.
        a = 12'h900; b = 12'h800; c = 12'h700; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        chk("flight.rst", {11'd0, out_valid}, 12'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 1; k++) begin
            tick();
            chk($sformatf("flight%0d", k), {11'd0, out_valid}, 12'd0);
            chk($sformatf("flight%0d.max", k), maxv, 12'h000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
